// File: rtl/imul_rr_sched_pkg.sv
// imul_sched_pkg: shared types and widths for the round-robin multiplier scheduler.
//   sched_state_e   : scheduler FSM state encoding
//   IMUL_REQ_NBITS  : request message width, {a[63:32], b[31:0]}
//   IMUL_RESP_NBITS : product width
package imul_sched_pkg;

  localparam int IMUL_REQ_NBITS  = 64;
  localparam int IMUL_RESP_NBITS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } sched_state_e;

endpackage

// File: rtl/imul_rr_sched_if.sv
// imul_rr_sched_if: bundles the requester-side streams and the multiplier-side
// handshake of the scheduler.
//   istream_* : NREQS request channels (val/rdy, 64-bit message each, packed)
//   ostream_* : NREQS response valids/readies, one shared 32-bit product bus
//   mul_req_* : request channel to the shared multiplier
//   mul_resp_*: product channel from the shared multiplier
// Modports: slave = the scheduler, master = the surrounding environment.
interface imul_rr_sched_if #(
  parameter int NREQS = 2
);
  import imul_sched_pkg::*;

  logic [NREQS-1:0]                istream_val;
  logic [NREQS-1:0]                istream_rdy;
  logic [IMUL_REQ_NBITS*NREQS-1:0] istream_msg;
  logic [NREQS-1:0]                ostream_val;
  logic [NREQS-1:0]                ostream_rdy;
  logic [IMUL_RESP_NBITS-1:0]      ostream_msg;
  logic                            mul_req_val;
  logic                            mul_req_rdy;
  logic [IMUL_REQ_NBITS-1:0]       mul_req_msg;
  logic                            mul_resp_val;
  logic                            mul_resp_rdy;
  logic [IMUL_RESP_NBITS-1:0]      mul_resp_msg;

  modport slave (
    input  istream_val, istream_msg, ostream_rdy,
    input  mul_req_rdy, mul_resp_val, mul_resp_msg,
    output istream_rdy, ostream_val, ostream_msg,
    output mul_req_val, mul_req_msg, mul_resp_rdy
  );

  modport master (
    output istream_val, istream_msg, ostream_rdy,
    output mul_req_rdy, mul_resp_val, mul_resp_msg,
    input  istream_rdy, ostream_val, ostream_msg,
    input  mul_req_val, mul_req_msg, mul_resp_rdy
  );

endinterface

// File: rtl/imul_rr_sched_arb.sv
// imul_rr_arb: combinational round-robin picker.
//   req       : request vector
//   ptr       : index holding highest priority; search runs ptr, ptr+1, ... mod NREQS
//   grant_oh  : one-hot grant (zero when nothing requests)
//   grant_idx : index of the granted requester
//   any       : at least one request present
module imul_rr_arb #(
  parameter int NREQS = 2,
  parameter int PTRW  = $clog2(NREQS)
) (
  input  logic [NREQS-1:0] req,
  input  logic [PTRW-1:0]  ptr,
  output logic [NREQS-1:0] grant_oh,
  output logic [PTRW-1:0]  grant_idx,
  output logic             any
);

  // ptr is always < NREQS, so a single conditional subtract implements the modulo.
  function automatic logic [PTRW-1:0] rot_idx(input logic [PTRW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQS) s = s - NREQS;
    return PTRW'(s);
  endfunction

  // Scan from lowest to highest priority; the last hit (closest to ptr) wins.
  always_comb begin
    logic [PTRW-1:0] c;
    grant_oh  = '0;
    grant_idx = '0;
    any       = 1'b0;
    c         = '0;
    for (int k = NREQS - 1; k >= 0; k--) begin
      c = rot_idx(ptr, k);
      if (req[c]) begin
        grant_oh    = '0;
        grant_oh[c] = 1'b1;
        grant_idx   = c;
        any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/imul_rr_sched.sv
// imul_rr_sched: shares one iterative 32x32->32 multiplier among NREQS requesters
// with round-robin fairness; one transaction in flight at a time.
//   clk, reset : clock, asynchronous active-high reset
//   io (slave) : requester streams and multiplier handshake (imul_rr_sched_if)
//   perf_grants: per-requester saturating grant counters, 16 bits each
//                (present only with IMUL_RR_SCHED_PERF_EN defined)
//
// state | meaning
// IDLE  | arbitrate; accept the granted request and latch its operands
// SEND  | present held operands to the multiplier until accepted
// WAIT  | wait for the product and latch it
// RESP  | present product to the owner until accepted; advance pointer
module imul_rr_sched
  import imul_sched_pkg::*;
#(
  parameter int NREQS = 2,
  parameter int PTRW  = $clog2(NREQS)
) (
  input  logic                   clk,
  input  logic                   reset,
  imul_rr_sched_if.slave         io
`ifdef IMUL_RR_SCHED_PERF_EN
  ,
  output logic [16*NREQS-1:0]    perf_grants
`endif
);

  sched_state_e               state_q, state_d;
  logic [PTRW-1:0]            ptr_q, ptr_d;
  logic [PTRW-1:0]            owner_q, owner_d;
  logic [IMUL_REQ_NBITS-1:0]  msg_q, msg_d;
  logic [IMUL_RESP_NBITS-1:0] prod_q, prod_d;

  logic [NREQS-1:0]           grant_oh;
  logic [PTRW-1:0]            grant_idx;
  logic                       grant_any;
  logic [IMUL_REQ_NBITS-1:0]  grant_msg;
  logic [PTRW-1:0]            owner_next;

  imul_rr_arb #(
    .NREQS (NREQS),
    .PTRW  (PTRW)
  ) u_arb (
    .req       (io.istream_val),
    .ptr       (ptr_q),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any       (grant_any)
  );

  always_comb begin
    grant_msg = '0;
    for (int i = 0; i < NREQS; i++) begin
      if (grant_oh[i]) grant_msg = io.istream_msg[i*IMUL_REQ_NBITS +: IMUL_REQ_NBITS];
    end
  end

  // The requester just served drops to lowest priority.
  assign owner_next = (owner_q == PTRW'(NREQS - 1)) ? '0 : owner_q + PTRW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      msg_q   <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      msg_q   <= msg_d;
      prod_q  <= prod_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    ptr_d           = ptr_q;
    owner_d         = owner_q;
    msg_d           = msg_q;
    prod_d          = prod_q;
    io.istream_rdy  = '0;
    io.ostream_val  = '0;
    io.mul_req_val  = 1'b0;
    io.mul_resp_rdy = 1'b0;
    case (state_q)
      IDLE: begin
        io.istream_rdy = grant_oh;
        if (grant_any) begin
          msg_d   = grant_msg;
          owner_d = grant_idx;
          state_d = SEND;
        end
      end
      SEND: begin
        io.mul_req_val = 1'b1;
        if (io.mul_req_rdy) state_d = WAIT;
      end
      WAIT: begin
        io.mul_resp_rdy = 1'b1;
        if (io.mul_resp_val) begin
          prod_d  = io.mul_resp_msg;
          state_d = RESP;
        end
      end
      RESP: begin
        io.ostream_val[owner_q] = 1'b1;
        if (io.ostream_rdy[owner_q]) begin
          ptr_d   = owner_next;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Registers reset to zero, so both buses read 0 in reset and stay stable while held.
  assign io.mul_req_msg = msg_q;
  assign io.ostream_msg = prod_q;

`ifdef IMUL_RR_SCHED_PERF_EN
  logic [15:0] perf_q [NREQS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREQS; i++) perf_q[i] <= '0;
    end else if (state_q == IDLE && grant_any && perf_q[grant_idx] != 16'hFFFF) begin
      perf_q[grant_idx] <= perf_q[grant_idx] + 16'd1;
    end
  end

  for (genvar g = 0; g < NREQS; g++) begin : g_perf
    assign perf_grants[16*g +: 16] = perf_q[g];
  end
`endif

`ifndef SYNTHESIS
  function automatic string line_trace();
    string s;
    s = "";
    for (int i = 0; i < NREQS; i++) begin
      s = {s, $sformatf("%b%b/%b%b ", io.istream_val[i], io.istream_rdy[i],
                        io.ostream_val[i], io.ostream_rdy[i])};
    end
    s = {s, $sformatf("%s o%0d", state_q.name(), owner_q)};
`ifdef IMUL_RR_SCHED_PERF_EN
    for (int i = 0; i < NREQS; i++) s = {s, $sformatf(" g%0d=%0d", i, perf_q[i])};
`endif
    return s;
  endfunction
`endif

endmodule

// File: tb/tb_imul_rr_sched.sv
module tb_imul_rr_sched;

  localparam int N  = 4;
  localparam int PW = 2;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  imul_rr_sched_if #(.NREQS(N)) io ();

`ifdef IMUL_RR_SCHED_PERF_EN
  logic [16*N-1:0] perf_grants;
`endif

  imul_rr_sched #(.NREQS(N), .PTRW(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
`ifdef IMUL_RR_SCHED_PERF_EN
    ,
    .perf_grants (perf_grants)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- stimulus controls ----------------
  logic [63:0] msgq [N][$];
  bit gap_en    = 1'b0;
  bit spur_en   = 1'b0;
  bit mrdy_rand = 1'b0;
  int ordy_mode = 0;     // 0 always ready, 1 random, 2 stalled
  int lat_min   = 34;
  int lat_max   = 34;

  // ---------------- requesters ----------------
  logic [N-1:0] cur_val;
  logic [63:0]  cur_msg [N];

  initial begin
    cur_val        = '0;
    for (int i = 0; i < N; i++) cur_msg[i] = '0;
    io.istream_val = '0;
    io.istream_msg = '0;
    io.ostream_rdy = '0;
    forever begin
      logic [N-1:0] hs;
      @(negedge clk);
      hs = io.istream_val & io.istream_rdy;
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (reset) cur_val[i] = 1'b0;
        else begin
          if (hs[i]) cur_val[i] = 1'b0;
          if (!cur_val[i] && msgq[i].size() > 0 && !(gap_en && $urandom_range(1, 0) == 1)) begin
            cur_val[i] = 1'b1;
            cur_msg[i] = msgq[i].pop_front();
          end
        end
        io.istream_msg[64*i +: 64] = cur_msg[i];
      end
      io.istream_val = cur_val;
      case (ordy_mode)
        0:       io.ostream_rdy = '1;
        1:       io.ostream_rdy = N'($urandom);
        default: io.ostream_rdy = '0;
      endcase
    end
  end

  // ---------------- multiplier model ----------------
  logic [31:0] m_prod;
  int          m_phase;
  int          m_cnt;

  initial begin
    m_phase         = 0;
    m_cnt           = 0;
    m_prod          = '0;
    io.mul_req_rdy  = 1'b0;
    io.mul_resp_val = 1'b0;
    io.mul_resp_msg = '0;
    forever begin
      logic        rq, rs;
      logic [63:0] rmsg;
      @(negedge clk);
      rq   = io.mul_req_val & io.mul_req_rdy;
      rs   = io.mul_resp_val & io.mul_resp_rdy;
      rmsg = io.mul_req_msg;
      @(posedge clk);
      #1;
      if (reset) m_phase = 0;
      else begin
        case (m_phase)
          0: if (rq) begin
               m_prod  = rmsg[63:32] * rmsg[31:0];
               m_cnt   = $urandom_range(lat_max, lat_min);
               m_phase = 1;
             end
          1: begin
               m_cnt--;
               if (m_cnt <= 0) m_phase = 2;
             end
          default: if (rs) m_phase = 0;
        endcase
      end
      io.mul_req_rdy = (m_phase == 0 && !reset) ? (mrdy_rand ? 1'($urandom) : 1'b1) : 1'b0;
      if (m_phase == 2) begin
        io.mul_resp_val = 1'b1;
        io.mul_resp_msg = m_prod;
      end else if (m_phase == 0 && spur_en && !reset) begin
        io.mul_resp_val = 1'($urandom);
        io.mul_resp_msg = $urandom;
      end else begin
        io.mul_resp_val = 1'b0;
        io.mul_resp_msg = '0;
      end
    end
  end

  // ---------------- transaction-level reference model + per-cycle compare ----------------
  bit          mb;       // a transaction is owned
  bit          ms;       // its operands were accepted by the multiplier
  bit          mr;       // its product came back
  int          mo;       // owner
  int          mptr;     // highest-priority requester
  logic [63:0] mmsg;
  logic [31:0] mprod;
  int          served_o [$];
  logic [31:0] served_p [$];
  int          gcnt [N];

  function automatic int pick(input int p, input logic [N-1:0] v);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  task automatic model_clear();
    mb = 1'b0; ms = 1'b0; mr = 1'b0; mo = 0; mptr = 0;
    mmsg = '0; mprod = '0;
    served_o.delete();
    served_p.delete();
    for (int i = 0; i < N; i++) gcnt[i] = 0;
  endtask

  initial begin
    model_clear();
    forever begin
      int           g;
      logic [N-1:0] exp_rdy, exp_ov;
      @(negedge clk);
      if (reset) begin
        model_clear();
        continue;
      end
      g       = mb ? -1 : pick(mptr, io.istream_val);
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      exp_ov = '0;
      if (mb && mr) exp_ov[mo] = 1'b1;
      chk("istream_rdy", io.istream_rdy, exp_rdy);
      chk("ostream_val", io.ostream_val, exp_ov);
      if (mb && mr) chk("ostream_msg", io.ostream_msg, mprod);
      chk("mul_req_val", io.mul_req_val, mb && !ms);
      if (mb && !ms) chk("mul_req_msg", io.mul_req_msg, mmsg);
      chk("mul_resp_rdy", io.mul_resp_rdy, mb && ms && !mr);
      // events taking effect at the coming clock edge
      if (g >= 0) begin
        mb    = 1'b1; ms = 1'b0; mr = 1'b0; mo = g;
        mmsg  = io.istream_msg[64*g +: 64];
        mprod = mmsg[63:32] * mmsg[31:0];
        gcnt[g]++;
      end else if (mb && !ms && io.mul_req_rdy) begin
        ms = 1'b1;
      end else if (mb && ms && !mr && io.mul_resp_val) begin
        mr = 1'b1;
      end else if (mb && mr && io.ostream_rdy[mo]) begin
        mb   = 1'b0;
        mptr = (mo + 1) % N;
        served_o.push_back(mo);
        served_p.push_back(mprod);
      end
    end
  end

  // ---------------- main sequence ----------------
  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_istream_rdy"}, io.istream_rdy, '0);
    chk({tag, "_ostream_val"}, io.ostream_val, '0);
    chk({tag, "_mul_req_val"}, io.mul_req_val, '0);
    chk({tag, "_mul_resp_rdy"}, io.mul_resp_rdy, '0);
    chk({tag, "_mul_req_msg"}, io.mul_req_msg, '0);
    chk({tag, "_ostream_msg"}, io.ostream_msg, '0);
  endtask

  task automatic do_reset(input string tag);
    @(posedge clk);
    #3 reset = 1'b1;
    #1 chk_zero_outputs(tag);
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
  endtask

  task automatic wait_served(input int n, input int budget, input string name);
    int c;
    c = 0;
    while (served_o.size() < n && c < budget) begin
      @(posedge clk);
      c++;
    end
    chk({name, "_timeout"}, 64'(served_o.size() >= n), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] held;
    int          c;

    // reset state
    #1 reset = 1'b1;
    #2 chk_zero_outputs("rst");
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;

    // single requester, long multiplier latency
    lat_min = 34; lat_max = 34;
    msgq[0].push_back({32'd3, 32'd7});
    wait_served(1, 200, "single");
    chk("single_owner", served_o[0], 0);
    chk("single_prod", served_p[0], 32'd21);

    // two valid together from reset: 0 first, then 1
    do_reset("rst2");
    lat_min = 2; lat_max = 5;
    msgq[0].push_back({32'd5, 32'd6});
    msgq[1].push_back({32'd7, 32'd8});
    wait_served(2, 100, "pair");
    chk("pair_owner0", served_o[0], 0);
    chk("pair_prod0", served_p[0], 32'd30);
    chk("pair_owner1", served_o[1], 1);
    chk("pair_prod1", served_p[1], 32'd56);

    // all requesters continuously valid: grants rotate and wrap
    do_reset("rst3");
    lat_min = 1; lat_max = 3;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) msgq[i].push_back({32'($urandom), 32'($urandom)});
    wait_served(8, 200, "rotate");
    for (int k = 0; k < 8; k++) chk($sformatf("rotate_order%0d", k), served_o[k], k % N);

    // response backpressure
    do_reset("rst4");
    lat_min = 2; lat_max = 2;
    ordy_mode = 2;
    msgq[0].push_back({32'd9, 32'd10});
    msgq[1].push_back({32'd11, 32'd12});
    c = 0;
    while (io.ostream_val == '0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    held = io.ostream_msg;
    chk("bp_prod", held, 32'd90);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_hold", io.ostream_msg, held);
      chk("bp_val", io.ostream_val, 4'b0001);
      chk("bp_no_mul_req", io.mul_req_val, 1'b0);
      chk("bp_no_grant", io.istream_rdy, '0);
    end
    ordy_mode = 0;
    wait_served(2, 100, "bp");
    chk("bp_prod1", served_p[1], 32'd132);

    // reset during WAIT abandons the transaction
    do_reset("rst5");
    lat_min = 20; lat_max = 20;
    msgq[0].push_back({32'($urandom), 32'($urandom)});
    c = 0;
    while (io.mul_resp_rdy !== 1'b1 && c < 100) begin
      @(negedge clk);
      c++;
    end
    chk("wait_reached", io.mul_resp_rdy, 1'b1);
    do_reset("rst_wait");
    lat_min = 3; lat_max = 3;
    msgq[1].push_back({32'hFFFF_FFFF, 32'd2});
    wait_served(1, 100, "after_rst");
    repeat (5) @(posedge clk);
    chk("after_rst_count", served_o.size(), 1);
    chk("after_rst_owner", served_o[0], 1);
    chk("after_rst_prod", served_p[0], 32'hFFFF_FFFE);

    // grant counting: 3 to requester 0, 2 to requester 1
    do_reset("rst6");
    lat_min = 1; lat_max = 2;
    for (int k = 0; k < 3; k++) msgq[0].push_back({32'(k + 1), 32'd3});
    for (int k = 0; k < 2; k++) msgq[1].push_back({32'(k + 4), 32'd5});
    wait_served(5, 100, "perf");
    for (int k = 0; k < 5; k++) chk($sformatf("perf_order%0d", k), served_o[k], (k % 2));
`ifdef IMUL_RR_SCHED_PERF_EN
    chk("perf_grants", perf_grants, {16'd0, 16'd0, 16'd2, 16'd3});
    for (int i = 0; i < N; i++) chk($sformatf("perf_model%0d", i), perf_grants[16*i +: 16], gcnt[i]);
`endif

    // randomized traffic with stalls, gaps and spurious multiplier responses
    do_reset("rst7");
    lat_min = 0; lat_max = 6;
    ordy_mode = 1; gap_en = 1'b1; spur_en = 1'b1; mrdy_rand = 1'b1;
    for (int k = 0; k < 60; k++) msgq[$urandom_range(N - 1, 0)].push_back({32'($urandom), 32'($urandom)});
    wait_served(60, 4000, "random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
